sru_filter_config_ctrl: RTL
===========================

// Module: sru_filter_config_ctrl
// PURPOSE
//  Configuration controller for a bank of NUM_SIG signal filter units.
//  Loads a 3-beat config frame (enable mask, constant values, hold count) over a valid/ready port into shadow registers.
//  Commits the frame atomically to the FruEn/RegConst vectors that drive the filter units.
//  Optionally auto-releases the override after a programmed number of cycles.
// PARAMETERS
//  NUM_SIG  8   number of filter units controlled; must be <= CFG_W
//  CFG_W    16  config beat width; also the width of the hold counter
// PORTS
//  clk       in   1        single clock; all state updates on rising edge
//  rst       in   1        synchronous, active-high reset
//  CfgValid  in   1        config beat valid
//  CfgReady  out  1        controller can accept a beat
//  CfgWord   in   CFG_W    beat payload; bits [NUM_SIG-1:0] used for beats 0 and 1
//  Abort     in   1        synchronous cancel: drop partial frame, release all filters
//  FruEn     out  NUM_SIG  per-unit filter enable (feeds each unit's FruEn)
//  RegConst  out  NUM_SIG  per-unit override constant (feeds each unit's RegConst)
//  Active    out  1        an override is currently applied (FruEn != 0)
//  Busy      out  1        loader FSM not in IDLE
//  Done      out  1        1-cycle pulse when a timed hold expires
// BEHAVIOUR
//  Reset: FruEn=0, RegConst=0, Active=0, Busy=0, Done=0, loader in IDLE, counter=0, shadows=0.
//  Beat handshake: a beat transfers on an edge with CfgValid & CfgReady. Beat 0 = enable mask, beat 1 = constants, beat 2 = hold count.
//  Loader FSM states: IDLE -> LD_CONST -> LD_HOLD -> COMMIT -> IDLE.
//   IDLE     CfgReady=1; a beat-0 transfer latches shadow_en and moves to LD_CONST.
//   LD_CONST CfgReady=1; a transfer latches shadow_const and moves to LD_HOLD.
//   LD_HOLD  CfgReady=1; a transfer latches shadow_hold and moves to COMMIT.
//   COMMIT   CfgReady=0; one cycle only; returns to IDLE.
//    At the COMMIT edge: FruEn<=shadow_en, RegConst<=shadow_const, counter<=shadow_hold.
//  Latency: beat 2 transfers at edge k; new FruEn/RegConst are visible after edge k+1.
//  Loading while Active: the current outputs and counter keep running until COMMIT replaces them.
//  Hold semantics:
//   shadow_hold=N>0: outputs are held for exactly N cycles. Counter decrements each edge while nonzero.
//    At the edge where counter==1: FruEn<=0, RegConst<=0, Done=1 for that following cycle.
//   shadow_hold=0: permanent; no decrement; released only by Abort, rst or a new commit.
//   shadow_en=0 at commit: releases all filters; Active=0; Done is not pulsed.
//  Active = |FruEn (registered). Busy = (state != IDLE).
//  Abort: at the next edge, loader->IDLE, shadows are discarded, FruEn=0, RegConst=0, counter=0. Done is not pulsed.
//  Simultaneous events:
//   Abort with COMMIT or with a beat transfer: Abort wins.
//   Counter expiry with COMMIT: COMMIT wins (new config loaded, no Done).
//   rst overrides everything.
//  Bits of CfgWord above NUM_SIG in beats 0/1 are ignored; beat 2 uses all CFG_W bits.
// STRUCTURE
//  Shared package sru_pkg: loader state encoding (IDLE, LD_CONST, LD_HOLD, COMMIT), beat index constants.
//  Sub-module sru_hold_timer: CFG_W down counter.
//   Ports: clk, rst, load, load_val, clear, expire pulse.
//   load_val=0 means the counter never expires.
//  Top level contains the loader FSM, shadow registers and output registers.
// TESTING
//  1. rst high 2 cycles -> all outputs 0, CfgReady=1 in IDLE.
//  2. Frame {0x05, 0x04, 0} -> FruEn=0x05, RegConst=0x04 one edge after beat 2; held indefinitely; Done never asserts.
//  3. Frame {0xFF, 0xAA, 3} -> outputs applied for exactly 3 cycles, then 0. Done high 1 cycle coincident with the first cleared cycle.
//  4. Abort asserted mid-frame (after beat 1) -> loader returns to IDLE, FruEn unchanged at 0.
//     Next full frame {0x01, 0x01, 0} applies normally.
//  5. While a hold of 10 is running, load frame {0x02, 0x00, 0} whose COMMIT lands on the expiry edge
//     -> FruEn=0x02, no Done pulse.
//  6. CfgValid toggling randomly (gaps between beats) -> beats accepted only on handshake.
//     CfgReady=0 during COMMIT; the committed values match the sent beats.

Source files
------------

// File: rtl/sru_pkg.sv
// rtl/sru_pkg.sv - shared loader state encoding and beat indices for the filter config controller
package sru_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_CONST = 2'd1,
    LD_HOLD  = 2'd2,
    COMMIT   = 2'd3
  } ld_state_t;

  localparam int BEAT_EN    = 0;
  localparam int BEAT_CONST = 1;
  localparam int BEAT_HOLD  = 2;

  function automatic logic is_loading(input ld_state_t s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/sru_hold_timer.sv
// rtl/sru_hold_timer.sv - CFG_W down counter; a load of zero parks it so it never expires
module sru_hold_timer #(
  parameter int CFG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CFG_W-1:0] load_val,
  input  logic             clear,
  output logic             expire
);

  logic [CFG_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Expiry is the edge on which the last held cycle ends.
  assign expire = (count == CFG_W'(1));

endmodule

// File: rtl/sru_filter_config_ctrl.sv
// rtl/sru_filter_config_ctrl.sv - 3-beat config loader committing enable/constant vectors to the filter bank
module sru_filter_config_ctrl
  import sru_pkg::*;
#(
  parameter int NUM_SIG = 8,
  parameter int CFG_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               CfgValid,
  output logic               CfgReady,
  input  logic [CFG_W-1:0]   CfgWord,
  input  logic               Abort,
  output logic [NUM_SIG-1:0] FruEn,
  output logic [NUM_SIG-1:0] RegConst,
  output logic               Active,
  output logic               Busy,
  output logic               Done
);

  ld_state_t          state;
  logic [NUM_SIG-1:0] shadow_en;
  logic [NUM_SIG-1:0] shadow_const;
  logic [CFG_W-1:0]   shadow_hold;
  logic               expire;
  logic               commit_now;
  logic [CFG_W-1:0]   hold_val;

  assign commit_now = (state == COMMIT) && !Abort;
  // An all-zero mask is a release, so it must not arm a Done pulse.
  assign hold_val   = (shadow_en == '0) ? '0 : shadow_hold;

  sru_hold_timer #(.CFG_W(CFG_W)) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (commit_now),
    .load_val (hold_val),
    .clear    (Abort),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      shadow_en    <= '0;
      shadow_const <= '0;
      shadow_hold  <= '0;
      FruEn        <= '0;
      RegConst     <= '0;
      Done         <= 1'b0;
    end else if (Abort) begin
      state        <= IDLE;
      shadow_en    <= '0;
      shadow_const <= '0;
      shadow_hold  <= '0;
      FruEn        <= '0;
      RegConst     <= '0;
      Done         <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (expire && state != COMMIT) begin
        FruEn    <= '0;
        RegConst <= '0;
        Done     <= 1'b1;
      end
      case (state)
        IDLE: if (CfgValid) begin
          shadow_en <= CfgWord[NUM_SIG-1:0];
          state     <= LD_CONST;
        end
        LD_CONST: if (CfgValid) begin
          shadow_const <= CfgWord[NUM_SIG-1:0];
          state        <= LD_HOLD;
        end
        LD_HOLD: if (CfgValid) begin
          shadow_hold <= CfgWord;
          state       <= COMMIT;
        end
        COMMIT: begin
          FruEn    <= shadow_en;
          RegConst <= shadow_const;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign CfgReady = (state != COMMIT);
  assign Busy     = is_loading(state);
  assign Active   = |FruEn;

endmodule
